johnson_decoder: RTL
====================

# johnson_decoder

Decodes the 5-bit twisted-ring (Johnson) code produced by the team's twisted-ring counter back into a decimal step index 0..9. It checks every sample for legality and for correct step-to-step succession, and tracks lock status and an error count. It sits on the receiving side of any link or probe that carries the raw counter state and gives downstream logic a verified, binary-coded position.

## Interface
- ERR_W, default 8: width of the saturating error counter.
- clk  input  1  system clock; all state updates on the rising edge.
- clear  input  1  asynchronous, active-low reset.
- valid_in  input  1  code_in is sampled on a rising edge only while high.
- code_in  input  5  Johnson code; bit 4 is the first stage (out_a), bit 0 the last (out_e).
- count  output  4  decoded step index 0..9.
- valid_out  output  1  count was updated from a legal code at the last sample.
- illegal  output  1  one-cycle pulse: the last sample was not one of the 10 legal codes.
- seq_err  output  1  one-cycle pulse: legal code while locked, but not the expected successor.
- wrap  output  1  one-cycle pulse: locked transition from index 9 to index 0.
- locked  output  1  high while in state LOCKED.
- err_count  output  ERR_W  count of illegal plus seq_err events; saturates at all-ones.

## Operation
- Legal code table, code_in[4:0] to index:
  - 00000 to 0, 10000 to 1, 11000 to 2, 11100 to 3, 11110 to 4
  - 11111 to 5, 01111 to 6, 00111 to 7, 00011 to 8, 00001 to 9
- All other 22 codes are illegal.
- Successor of index i is (i+1) mod 10. The block holds prev, the last legal index.
- FSM states: HUNT (reset state), CHECK, LOCKED. Transitions occur only on edges with valid_in=1:
  - HUNT: legal code goes to CHECK and loads prev. Illegal code stays in HUNT; illegal pulses and err_count increments.
  - CHECK: successor of prev goes to LOCKED. Any other legal code stays in CHECK and reloads prev. Illegal code goes to HUNT with illegal pulse and err_count increment.
  - LOCKED: successor stays in LOCKED; wrap pulses if prev=9. Legal non-successor (repeated code included) goes to CHECK, reloads prev, pulses seq_err and increments err_count. Illegal code goes to HUNT with illegal pulse and err_count increment.
- On a legal sample: count takes the new index and valid_out=1.
- On an illegal sample: count holds its value and valid_out=0.
- Pulses are never raised in HUNT or CHECK except illegal.
- valid_in=0: state, prev, count, locked and err_count hold. valid_out, illegal, seq_err and wrap go to 0.
- err_count increments by exactly 1 per event and sticks at 2^ERR_W-1. Only clear resets it.

## Timing
- All outputs are registered. Latency is one edge: the sample taken at edge n is reflected in outputs right after edge n.
- locked rises on the same edge that accepts the successor sample, i.e. after the second consecutive good sample. It falls on the edge that accepts the offending sample.
- Back-to-back samples on every edge are supported. There is no stall and no backpressure.
- clear low immediately forces, with no clock needed: count=0, valid_out=0, illegal=0, seq_err=0, wrap=0, locked=0, err_count=0, state=HUNT, prev=0.
- Reset mid-sequence discards lock; two good samples are needed after release. The first edge with clear high may sample.
- Simultaneous events: wrap and seq_err are mutually exclusive by construction. illegal and seq_err are exclusive.

## Test plan
- Reset: drive clear=0 with arbitrary inputs. Required: all outputs 0 at once and held; after release with valid_in=0, outputs stay 0.
- Lock-up: feed 00000, 10000, 11000 on consecutive edges. Required: count 0,1,2; valid_out=1 each cycle; locked=0 after the first edge and 1 after the second; err_count=0.
- Full cycle: while locked, feed the 10 codes from 00000 through 00001, then 00000. Required: count 0..9 then 0; wrap=1 only in the cycle after 00001 to 00000; no seq_err.
- Illegal code: locked at index 6, feed 10100. Required: illegal=1, valid_out=0, count stays 6, locked=0, err_count=1. Then feeding 00111 then 00011 gives count 7 with locked 0, then count 8 with locked 1.
- Counter cleared mid-run: locked at 11000 (index 2), feed 00000. Required: seq_err=1, count=0, locked=0, err_count increments. Then 10000 gives locked=1. A gap with valid_in=0 between samples changes nothing.
- Saturation and async reset: with ERR_W=2, feed 5 illegal codes. Required: err_count=3 (held). Then pulse clear low mid-clock-period. Required: err_count=0 and locked=0 immediately.

Source files
------------

// File: rtl/johnson_decoder.sv
// Johnson (twisted-ring) code decoder: maps a 5-bit ring state to a step
// index 0..9, checks legality and succession, tracks lock and error count.
module johnson_decoder #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             valid_in,
    input  logic [4:0]       code_in,
    output logic [3:0]       count,
    output logic             valid_out,
    output logic             illegal,
    output logic             seq_err,
    output logic             wrap,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        HUNT,
        CHECK,
        LOCKED
    } state_t;

    state_t     state;
    logic [3:0] prev;
    logic       legal;
    logic [3:0] idx;
    logic [3:0] succ;
    logic       is_succ;
    logic       err_sat;

    always_comb begin
        legal = 1'b1;
        idx   = 4'd0;
        unique case (code_in)
            5'b00000: idx = 4'd0;
            5'b10000: idx = 4'd1;
            5'b11000: idx = 4'd2;
            5'b11100: idx = 4'd3;
            5'b11110: idx = 4'd4;
            5'b11111: idx = 4'd5;
            5'b01111: idx = 4'd6;
            5'b00111: idx = 4'd7;
            5'b00011: idx = 4'd8;
            5'b00001: idx = 4'd9;
            default:  legal = 1'b0;
        endcase
    end

    assign succ    = (prev == 4'd9) ? 4'd0 : prev + 4'd1;
    assign is_succ = (idx == succ);
    assign err_sat = &err_count;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state     <= HUNT;
            prev      <= 4'd0;
            count     <= 4'd0;
            valid_out <= 1'b0;
            illegal   <= 1'b0;
            seq_err   <= 1'b0;
            wrap      <= 1'b0;
            locked    <= 1'b0;
            err_count <= '0;
        end else begin
            valid_out <= 1'b0;
            illegal   <= 1'b0;
            seq_err   <= 1'b0;
            wrap      <= 1'b0;
            if (valid_in) begin
                if (!legal) begin
                    state   <= HUNT;
                    locked  <= 1'b0;
                    illegal <= 1'b1;
                    if (!err_sat)
                        err_count <= err_count + ERR_W'(1);
                end else begin
                    count     <= idx;
                    valid_out <= 1'b1;
                    prev      <= idx;
                    unique case (state)
                        HUNT: state <= CHECK;
                        CHECK: begin
                            if (is_succ) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end
                        LOCKED: begin
                            if (is_succ) begin
                                wrap <= (prev == 4'd9);
                            end else begin
                                // any break in succession drops back to re-verify
                                state   <= CHECK;
                                locked  <= 1'b0;
                                seq_err <= 1'b1;
                                if (!err_sat)
                                    err_count <= err_count + ERR_W'(1);
                            end
                        end
                        default: begin
                            state  <= HUNT;
                            locked <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule
